baby_run_control: RTL and testbench

Front-panel run/stop/single-step controller for the Baby. It synchronises and debounces the three raw panel switches and arbitrates them against the STP-executed and end-of-cycle pulses from the control unit. It emits one-tick set/reset pulses that drive the S and R inputs of the machine's run-state SR flip-flop. It sits directly upstream of that flip-flop and shares its clock, tick and reset.

---
 rtl/baby_run_control.sv | 156 +++++++++++++++
 tb/tb_baby_run_control.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baby_run_control.sv
// rtl/baby_run_control.sv - front-panel run/stop/single-step controller for the Baby
// Synchronises and debounces the panel switches and drives the run flip-flop S/R inputs.
module baby_run_control #(
    parameter int DEBOUNCE_W = 4
) (
    input  logic       reset,
    input  logic       s_clock,
    input  logic       tick,
    input  logic       run_sw,
    input  logic       stop_sw,
    input  logic       step_sw,
    input  logic       stp_exec,
    input  logic       cycle_end,
    input  logic       run_q,
    output logic       set_run,
    output logic       clr_run,
    output logic [1:0] mode,
    output logic       desync
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RUNNING   = 2'b01,
        STEP_WAIT = 2'b10
    } state_t;

    localparam int SW_RUN  = 0;
    localparam int SW_STOP = 1;
    localparam int SW_STEP = 2;

    // Value one below all-ones: the next increment would complete the stable window.
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = {{(DEBOUNCE_W-1){1'b1}}, 1'b0};
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE  = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    logic [2:0]                 w_raw;
    logic [2:0]                 r_sync1;
    logic [2:0]                 r_sync2;
    logic [2:0]                 r_deb;
    logic [2:0]                 r_prev;
    logic [2:0]                 r_press;
    logic [2:0][DEBOUNCE_W-1:0] r_cnt;

    state_t r_state;
    state_t w_next_state;
    logic   w_set;
    logic   w_clr;
    logic   w_halt;
    logic   r_set_run;
    logic   r_clr_run;
    logic   r_desync_seen;
    logic   r_desync;

    assign w_raw = {step_sw, stop_sw, run_sw};

    always_ff @(posedge s_clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge s_clock or posedge reset) begin
        if (reset) begin
            r_deb   <= 3'b000;
            r_prev  <= 3'b000;
            r_press <= 3'b000;
            r_cnt   <= '0;
        end else if (tick) begin
            r_prev  <= r_deb;
            r_press <= r_deb & ~r_prev;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign w_halt = r_press[SW_STOP] | stp_exec;

    always_comb begin
        w_next_state = r_state;
        w_set        = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_halt) begin
                    w_next_state = IDLE;
                end else if (r_press[SW_STEP]) begin
                    w_set        = 1'b1;
                    w_next_state = STEP_WAIT;
                end else if (r_press[SW_RUN]) begin
                    w_set        = 1'b1;
                    w_next_state = RUNNING;
                end
            end
            RUNNING: begin
                if (w_halt) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            STEP_WAIT: begin
                if (w_halt || cycle_end) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs only move on tick edges, so a pulse stretches across tick=0 gaps.
    always_ff @(posedge s_clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_set_run <= 1'b0;
            r_clr_run <= 1'b0;
        end else if (tick) begin
            r_state   <= w_next_state;
            r_set_run <= w_set;
            r_clr_run <= w_clr;
        end
    end

    always_ff @(posedge s_clock or posedge reset) begin
        if (reset) begin
            r_desync_seen <= 1'b0;
            r_desync      <= 1'b0;
        end else if (tick) begin
            if ((r_state != IDLE) && !run_q) begin
                r_desync_seen <= 1'b1;
                r_desync      <= r_desync_seen;
            end else begin
                r_desync_seen <= 1'b0;
                r_desync      <= 1'b0;
            end
        end
    end

    assign set_run = r_set_run;
    assign clr_run = r_clr_run;
    assign mode    = r_state;
    assign desync  = r_desync;

endmodule

// File: tb/tb_baby_run_control.sv
// tb/tb_baby_run_control.sv - self-checking bench for baby_run_control
module tb_baby_run_control;

    logic       reset, s_clock, tick;
    logic       run_sw, stop_sw, step_sw, stp_exec, cycle_end, run_q;
    logic       set_run, clr_run, desync;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 0;
    bit force_lo = 0;
    logic rq;

    typedef struct {
        int cyc;
        bit is_set;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        bit         run;
        bit         stop;
        bit         step;
        bit         exp_set;
        logic [1:0] exp_mode;
    } vec_t;
    vec_t vecs[6];

    baby_run_control #(.DEBOUNCE_W(4)) dut (
        .reset    (reset),
        .s_clock  (s_clock),
        .tick     (tick),
        .run_sw   (run_sw),
        .stop_sw  (stop_sw),
        .step_sw  (step_sw),
        .stp_exec (stp_exec),
        .cycle_end(cycle_end),
        .run_q    (run_q),
        .set_run  (set_run),
        .clr_run  (clr_run),
        .mode     (mode),
        .desync   (desync)
    );

    initial s_clock = 0;
    always #5 s_clock = ~s_clock;

    always @(posedge s_clock) cyc <= cyc + 1;

    // Behavioural model of the downstream run flip-flop.
    always @(posedge s_clock or posedge reset) begin
        if (reset) rq <= 1'b0;
        else if (tick) begin
            if (set_run) rq <= 1'b1;
            else if (clr_run) rq <= 1'b0;
        end
    end
    assign run_q = force_lo ? 1'b0 : rq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge s_clock) begin
        ev_t e;
        if (mon_en && !reset) begin
            if (set_run && clr_run) check("pulse_exclusive", 1, 0);
            if (set_run || clr_run) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: set_run=%0b clr_run=%0b at cycle %0d, expected no pulse",
                             set_run, clr_run, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind_set", set_run, e.is_set);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge s_clock);
    endtask

    task automatic do_reset();
        reset = 1; tick = 1;
        run_sw = 0; stop_sw = 0; step_sw = 0;
        stp_exec = 0; cycle_end = 0; force_lo = 0;
        sb.delete();
        repeat (2) @(negedge s_clock);
        reset = 0;
        @(negedge s_clock);
    endtask

    task automatic push_ev(input int c, input bit is_set);
        ev_t e;
        e.cyc = c;
        e.is_set = is_set;
        sb.push_back(e);
    endtask

    initial begin
        int e0;
        int n;
        vecs[0] = '{1, 0, 0, 1, 2'b01};
        vecs[1] = '{0, 0, 1, 1, 2'b10};
        vecs[2] = '{1, 1, 0, 0, 2'b00};
        vecs[3] = '{1, 0, 1, 1, 2'b10};
        vecs[4] = '{0, 1, 0, 0, 2'b00};
        vecs[5] = '{1, 1, 1, 0, 2'b00};

        reset = 1; tick = 1;
        run_sw = 0; stop_sw = 0; step_sw = 0;
        stp_exec = 0; cycle_end = 0;
        #3;
        check("reset_set_run", set_run, 0);
        check("reset_clr_run", clr_run, 0);
        check("reset_mode", mode, 0);
        check("reset_desync", desync, 0);
        mon_en = 1;

        // Switch combinations pressed on the same edge from IDLE.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            run_sw = vecs[v].run; stop_sw = vecs[v].stop; step_sw = vecs[v].step;
            e0 = cyc + 1;
            if (vecs[v].exp_set) push_ev(e0 + 18, 1);
            wait_until(e0 + 18);
            check("vec_set_at_18", set_run, vecs[v].exp_set);
            wait_until(e0 + 20);
            check("vec_mode", mode, vecs[v].exp_mode);
            check("vec_set_one_tick", set_run, 0);
            check("vec_sb_drained", sb.size(), 0);
            run_sw = 0; stop_sw = 0; step_sw = 0;
        end

        // RUNNING, then STP executed.
        do_reset();
        run_sw = 1;
        e0 = cyc + 1;
        push_ev(e0 + 18, 1);
        wait_until(e0 + 17);
        check("run_before_18", set_run, 0);
        wait_until(e0 + 20);
        run_sw = 0;
        check("run_mode", mode, 2'b01);
        check("run_q_model", run_q, 1);
        stp_exec = 1;
        n = cyc + 1;
        push_ev(n, 0);
        @(negedge s_clock);
        stp_exec = 0;
        check("stp_clr", clr_run, 1);
        check("stp_mode", mode, 2'b00);
        repeat (25) @(negedge s_clock);
        check("stp_no_more", sb.size(), 0);
        check("stp_desync", desync, 0);

        // Single step ended by cycle_end, then by stp_exec and cycle_end together.
        do_reset();
        step_sw = 1;
        e0 = cyc + 1;
        push_ev(e0 + 18, 1);
        wait_until(e0 + 18);
        check("step_mode", mode, 2'b10);
        step_sw = 0;
        repeat (5) @(negedge s_clock);
        cycle_end = 1;
        n = cyc + 1;
        push_ev(n, 0);
        @(negedge s_clock);
        cycle_end = 0;
        check("cycle_end_mode", mode, 2'b00);
        repeat (20) @(negedge s_clock);
        step_sw = 1;
        e0 = cyc + 1;
        push_ev(e0 + 18, 1);
        wait_until(e0 + 20);
        step_sw = 0;
        check("step2_mode", mode, 2'b10);
        stp_exec = 1; cycle_end = 1;
        n = cyc + 1;
        push_ev(n, 0);
        @(negedge s_clock);
        stp_exec = 0; cycle_end = 0;
        check("dual_end_mode", mode, 2'b00);
        repeat (3) @(negedge s_clock);
        check("dual_end_single", sb.size(), 0);

        // Bouncing RUN switch, then held.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            run_sw = (k % 2 == 0);
            repeat (10) @(negedge s_clock);
        end
        check("bounce_mode", mode, 2'b00);
        run_sw = 1;
        e0 = cyc + 1;
        push_ev(e0 + 18, 1);
        wait_until(e0 + 22);
        check("bounce_final_mode", mode, 2'b01);
        check("bounce_sb_drained", sb.size(), 0);

        // Desync detection and asynchronous reset while RUNNING.
        do_reset();
        run_sw = 1;
        e0 = cyc + 1;
        push_ev(e0 + 18, 1);
        wait_until(e0 + 22);
        run_sw = 0;
        check("ds_pre", desync, 0);
        force_lo = 1;
        @(negedge s_clock);
        check("ds_after_1", desync, 0);
        @(negedge s_clock);
        check("ds_after_2", desync, 1);
        check("ds_mode_held", mode, 2'b01);
        #2;
        reset = 1;
        #1;
        check("mid_reset_set", set_run, 0);
        check("mid_reset_clr", clr_run, 0);
        check("mid_reset_mode", mode, 0);
        check("mid_reset_desync", desync, 0);
        force_lo = 0;
        repeat (2) @(negedge s_clock);
        reset = 0;
        repeat (25) @(negedge s_clock);
        check("post_reset_mode", mode, 0);
        check("post_reset_sb", sb.size(), 0);

        // tick=0 stretches a pending pulse.
        mon_en = 0;
        do_reset();
        run_sw = 1;
        e0 = cyc + 1;
        wait_until(e0 + 18);
        check("stretch_start", set_run, 1);
        tick = 0;
        repeat (3) @(negedge s_clock);
        check("stretch_held", set_run, 1);
        check("stretch_mode", mode, 2'b01);
        tick = 1;
        @(negedge s_clock);
        check("stretch_end", set_run, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
